// File: rtl/glitch_filter.sv
// glitch_filter: two-flop synchronizer followed by a persistence filter.
// A new level must be seen on the synchronized input for STABLE_CYCLES
// consecutive edges before dout follows; shorter pulses are counted as
// glitches in a saturating counter and a sticky flag.
`timescale 1ns/1ps
module glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clear_glitch,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             glitch_flag
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Run count at which the next mismatching edge completes STABLE_CYCLES.
  localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;
  logic [7:0]       r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  logic             w_mismatch;
  logic             w_abort;

  assign w_mismatch = (r_s2 != r_dout);
  assign w_abort    = (r_state == ST_PENDING) && !w_mismatch;

  // Synchronizer, filter FSM with run counter, and registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= RESET_VAL;
      r_s2    <= RESET_VAL;
      r_dout  <= RESET_VAL;
      r_state <= ST_STABLE;
      r_run   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_mismatch) begin
            r_state <= ST_PENDING;
            r_run   <= 8'd1;
          end
        end
        ST_PENDING: begin
          if (!w_mismatch) begin
            r_state <= ST_STABLE;
            r_run   <= '0;
          end else if (r_run == RUN_LAST) begin
            r_dout  <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
            r_state <= ST_STABLE;
            r_run   <= '0;
          end else begin
            r_run <= r_run + 8'd1;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_run   <= '0;
        end
      endcase
    end
  end

  // Saturating glitch counter and sticky flag; clear beats a same-edge abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (clear_glitch) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (w_abort) begin
      r_flag <= 1'b1;
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout        = r_dout;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign glitch_cnt  = r_cnt;
  assign glitch_flag = r_flag;

endmodule

// File: tb/tb_glitch_filter.sv
// Self-checking bench for glitch_filter: two instances (8-bit and 2-bit
// glitch counters) share stimulus and are compared every cycle against a
// run-length reference model, plus directed scenario checks.
`timescale 1ns/100ps
module tb_glitch_filter;

  localparam int SC = 4;
  localparam logic RV = 1'b0;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       din;
  logic       din_drv;
  logic       use_logic;
  logic       dout, rise, fall, glitch_flag;
  logic [7:0] glitch_cnt;
  logic       dout2, rise2, fall2, glitch_flag2;
  logic [1:0] cnt2;

  // Upstream 4-input logic with unequal gate delays (source of hazards).
  logic a, b, c, d;
  logic na, t1, t2, f;
  assign #2 na = ~a;
  assign #1 t1 = a & b;
  assign #1 t2 = na & c;
  assign #1 f  = (t1 | t2) ^ d;

  assign din = use_logic ? f : din_drv;

  glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(8), .RESET_VAL(RV)) u_dut (
    .clk(clk), .reset(reset), .din(din), .clear_glitch(clear),
    .dout(dout), .rise(rise), .fall(fall),
    .glitch_cnt(glitch_cnt), .glitch_flag(glitch_flag)
  );

  glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(2), .RESET_VAL(RV)) u_dut2 (
    .clk(clk), .reset(reset), .din(din), .clear_glitch(clear),
    .dout(dout2), .rise(rise2), .fall(fall2),
    .glitch_cnt(cnt2), .glitch_flag(glitch_flag2)
  );

  initial clk = 1'b0;
  always #0.5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: synchronizer as a 2-deep delay, filter as a count of
  // consecutive edges where the delayed input disagrees with the output.
  logic m_s1 = RV, m_s2 = RV, m_dout = RV, m_rise = 0, m_fall = 0, m_flag = 0;
  int   m_run = 0, m_cnt8 = 0, m_cnt2 = 0;

  function automatic void model_edge();
    logic s2v;
    logic ab;
    if (reset) begin
      m_s1 = RV; m_s2 = RV; m_dout = RV; m_run = 0;
      m_rise = 0; m_fall = 0; m_cnt8 = 0; m_cnt2 = 0; m_flag = 0;
    end else begin
      s2v = m_s2; m_s2 = m_s1; m_s1 = din;
      m_rise = 0; m_fall = 0; ab = 0;
      if (s2v != m_dout) begin
        m_run++;
        if (m_run == SC) begin
          m_dout = s2v; m_rise = s2v; m_fall = ~s2v; m_run = 0;
        end
      end else begin
        ab = (m_run > 0);
        m_run = 0;
      end
      if (clear) begin
        m_cnt8 = 0; m_cnt2 = 0; m_flag = 0;
      end else if (ab) begin
        m_flag = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endfunction

  function automatic logic truth(input int unsigned i);
    logic [3:0] v;
    v = 4'(i);
    return ((v[3] & v[2]) | (~v[3] & v[1])) ^ v[0];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #0.2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    din_drv = 1'b1;
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({dout, rise, fall, glitch_flag} !== {RV, 3'b000} || glitch_cnt !== 8'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_state dout=%b rise=%b fall=%b flag=%b cnt=%0d cnt2=%0d required dout=%b others 0",
               dout, rise, fall, glitch_flag, glitch_cnt, cnt2, RV);
    end
    reset = 1'b0;
    din_drv = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_latency();
    int lat = 0;
    int rises = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    din_drv = 1'b1;
    // The edge after this assignment samples the new level; it is edge 1.
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++;
      if (dout !== m_dout || rise !== m_rise || fall !== m_fall || glitch_cnt !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL latency_cycle t=%0t dout=%b/%b rise=%b/%b fall=%b/%b cnt=%0d/%0d",
                 $time, dout, m_dout, rise, m_rise, fall, m_fall, glitch_cnt, m_cnt8);
      end
      if (rise === 1'b1) rises++;
      if (dout === 1'b1 && lat == 0) lat = n;
    end
    checks++;
    if (lat != SC + 2 || rises != 1 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL latency got edge=%0d rises=%0d cnt=%0d required edge=%0d rises=1 cnt=0",
               lat, rises, glitch_cnt, SC + 2);
    end
  endtask

  task automatic test_reject();
    int pulses = 0;
    din_drv = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    for (int n = 0; n < 14; n++) begin
      din_drv = (n < 3);
      step();
      checks++;
      if (dout !== m_dout || rise !== m_rise || fall !== m_fall ||
          glitch_flag !== m_flag || glitch_cnt !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL reject_cycle t=%0t dout=%b/%b rise=%b/%b fall=%b/%b flag=%b/%b cnt=%0d/%0d",
                 $time, dout, m_dout, rise, m_rise, fall, m_fall, glitch_flag, m_flag, glitch_cnt, m_cnt8);
      end
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    checks++;
    if (dout !== 1'b0 || pulses != 0 || glitch_cnt !== 8'd1 || glitch_flag !== 1'b1) begin
      errors++;
      $display("FAIL reject_3 dout=%b pulses=%0d cnt=%0d flag=%b required dout=0 pulses=0 cnt=1 flag=1",
               dout, pulses, glitch_cnt, glitch_flag);
    end
  endtask

  task automatic test_accept();
    int highs = 0, rises = 0, falls = 0;
    din_drv = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    for (int n = 0; n < 18; n++) begin
      din_drv = (n < 4);
      step();
      checks++;
      if (dout !== m_dout || rise !== m_rise || fall !== m_fall || glitch_cnt !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL accept_cycle t=%0t dout=%b/%b rise=%b/%b fall=%b/%b cnt=%0d/%0d",
                 $time, dout, m_dout, rise, m_rise, fall, m_fall, glitch_cnt, m_cnt8);
      end
      if (dout === 1'b1) highs++;
      if (rise === 1'b1) rises++;
      if (fall === 1'b1) falls++;
    end
    checks++;
    if (highs != 4 || rises != 1 || falls != 1 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL accept_4 high=%0d rises=%0d falls=%0d cnt=%0d required high=4 rises=1 falls=1 cnt=0",
               highs, rises, falls, glitch_cnt);
    end
  endtask

  task automatic test_saturate();
    din_drv = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    for (int p = 0; p < 5; p++) begin
      din_drv = 1'b1;
      step();
      din_drv = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (cnt2 !== 2'(m_cnt2) || glitch_cnt !== 8'(m_cnt8) || glitch_flag2 !== m_flag) begin
        errors++;
        $display("FAIL sat_pulse p=%0d cnt2=%0d/%0d cnt=%0d/%0d flag2=%b/%b",
                 p, cnt2, m_cnt2, glitch_cnt, m_cnt8, glitch_flag2, m_flag);
      end
    end
    checks++;
    if (cnt2 !== 2'd3 || glitch_cnt !== 8'd5 || glitch_flag2 !== 1'b1) begin
      errors++;
      $display("FAIL saturate cnt2=%0d cnt=%0d flag2=%b required cnt2=3 cnt=5 flag2=1",
               cnt2, glitch_cnt, glitch_flag2);
    end
    // Sixth 1-cycle pulse: its abort lands on the third edge after sampling.
    din_drv = 1'b1;
    step();
    din_drv = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (cnt2 !== 2'd0 || glitch_flag2 !== 1'b0 || glitch_cnt !== 8'd0 || glitch_flag !== 1'b0 ||
        m_cnt2 != 0) begin
      errors++;
      $display("FAIL clear_wins cnt2=%0d flag2=%b cnt=%0d flag=%b required all 0",
               cnt2, glitch_flag2, glitch_cnt, glitch_flag);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (cnt2 !== 2'd0 || glitch_cnt !== 8'd0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL after_clear cnt2=%0d cnt=%0d dout=%b required 0 0 0", cnt2, glitch_cnt, dout);
    end
  endtask

  task automatic test_reset_pending();
    int lat = 0;
    din_drv = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    din_drv = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (dout !== 1'b0 || rise !== 1'b0 || glitch_cnt !== 8'd0 || glitch_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending dout=%b rise=%b cnt=%0d flag=%b required 0 0 0 0",
               dout, rise, glitch_cnt, glitch_flag);
    end
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (dout === 1'b1 && lat == 0) lat = n;
    end
    checks++;
    if (lat != SC + 2 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_pending_latency edge=%0d cnt=%0d required edge=%0d cnt=0",
               lat, glitch_cnt, SC + 2);
    end
  endtask

  task automatic test_sweep();
    {a, b, c, d} = 4'b0000;
    use_logic = 1'b1;
    #10;
    do_reset();
    for (int unsigned i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) {a, b, c, d} = 4'(i);
      for (int k = 1; k <= 10; k++) begin
        step();
        checks++;
        if (dout !== m_dout || rise !== m_rise || fall !== m_fall ||
            glitch_cnt !== 8'(m_cnt8) || glitch_flag !== m_flag) begin
          errors++;
          $display("FAIL sweep_cycle step=%0d t=%0t dout=%b/%b rise=%b/%b fall=%b/%b cnt=%0d/%0d",
                   i, $time, dout, m_dout, rise, m_rise, fall, m_fall, glitch_cnt, m_cnt8);
        end
        // Previous step's value has settled and the new one cannot yet show.
        if (k == 5 && i > 0) begin
          checks++;
          if (dout !== truth(i - 1)) begin
            errors++;
            $display("FAIL sweep_truth step=%0d dout=%b required %b", i - 1, dout, truth(i - 1));
          end
        end
        if (i == 16 && k == 5) break;
      end
    end
    use_logic = 1'b0;
  endtask

  task automatic test_random();
    int left = 0;
    din_drv = 1'b0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if (left == 0) begin
        din_drv = ~din_drv;
        left = $urandom_range(1, 7);
      end
      left--;
      clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (dout !== m_dout || rise !== m_rise || fall !== m_fall || glitch_flag !== m_flag ||
          glitch_cnt !== 8'(m_cnt8) || cnt2 !== 2'(m_cnt2) || glitch_flag2 !== m_flag) begin
        errors++;
        $display("FAIL random t=%0t dout=%b/%b rise=%b/%b fall=%b/%b flag=%b/%b cnt=%0d/%0d cnt2=%0d/%0d",
                 $time, dout, m_dout, rise, m_rise, fall, m_fall, glitch_flag, m_flag,
                 glitch_cnt, m_cnt8, cnt2, m_cnt2);
      end
    end
    clear = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    din_drv = 1'b0;
    use_logic = 1'b0;
    {a, b, c, d} = 4'b0000;
    #0.2;
    test_reset();
    test_latency();
    test_reject();
    test_accept();
    test_saturate();
    test_reset_pending();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
